// File: rtl/matrix_row_scheduler.sv
// matrix_row_scheduler
//   Double-buffered row loader and row scanner for a ROWS x COLS display matrix.
//   Row words are written into a shadow frame over a valid/ready handshake; a
//   complete shadow frame replaces the active frame only when the scan wraps from
//   the last row to row 0, so the display never shows a mix of two frames.
// Ports
//   clk        : clock, all logic on posedge
//   rst        : synchronous reset, active-high
//   clr        : abort the partially loaded frame and zero the shadow frame
//   in_valid   : row word offered
//   in_ready   : row word accepted when in_valid && in_ready (combinational)
//   in_data    : row word, bit 0 = leftmost column
//   row_sel    : one-hot scanned row, bit 0 = row 0
//   col_out    : active-frame data of the scanned row
//   frame_out  : active frame, row r at [r*COLS +: COLS]
//   frame_swap : one-cycle pulse after the active frame was replaced
module matrix_row_scheduler #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 12,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:COLS-1]        in_data,
  output logic [0:ROWS-1]        row_sel,
  output logic [0:COLS-1]        col_out,
  output logic [0:ROWS*COLS-1]   frame_out,
  output logic                   frame_swap
);

  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRAME_W = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   load_idx_q, load_idx_d;
  logic [ROW_W-1:0]   scan_row_q, scan_row_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [0:FRAME_W-1] shadow_q, shadow_d;
  logic [0:FRAME_W-1] active_q, active_d;
  logic [0:ROWS-1]    row_sel_d;
  logic [0:COLS-1]    col_d;
  logic               row_end;
  logic               boundary;
  logic               do_swap;

  // End of the current row's dwell, and end of the whole scan frame.
  assign row_end  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign boundary = row_end && (scan_row_q == ROW_W'(ROWS - 1));

  // Load FSM: fills the shadow frame, then parks in COMMIT until the scan wraps.
  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    shadow_d   = shadow_q;
    do_swap    = 1'b0;
    in_ready   = (state_q != COMMIT) && !clr;

    if (clr) begin
      // clr overrides everything, including a swap due on this edge.
      state_d    = IDLE;
      load_idx_d = '0;
      shadow_d   = '0;
    end else begin
      case (state_q)
        IDLE, FILL: begin
          if (in_valid) begin
            shadow_d[int'(load_idx_q) * COLS +: COLS] = in_data;
            if (load_idx_q == ROW_W'(ROWS - 1)) begin
              state_d    = COMMIT;
              load_idx_d = '0;
            end else begin
              state_d    = FILL;
              load_idx_d = load_idx_q + ROW_W'(1);
            end
          end
        end
        COMMIT: begin
          if (boundary) begin
            do_swap = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Scan sequencer; row_sel/col_out are computed from the post-edge row and frame
  // so a freshly swapped frame shows on row 0 in the same cycle it becomes active.
  always_comb begin
    div_d      = div_q + DIV_W'(1);
    scan_row_d = scan_row_q;
    if (row_end) begin
      div_d = '0;
      if (scan_row_q == ROW_W'(ROWS - 1)) begin
        scan_row_d = '0;
      end else begin
        scan_row_d = scan_row_q + ROW_W'(1);
      end
    end

    active_d = do_swap ? shadow_q : active_q;

    row_sel_d             = '0;
    row_sel_d[scan_row_d] = 1'b1;
    col_d                 = active_d[int'(scan_row_d) * COLS +: COLS];
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      load_idx_q <= '0;
      scan_row_q <= '0;
      div_q      <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      row_sel    <= {1'b1, {(ROWS-1){1'b0}}};
      col_out    <= '0;
      frame_swap <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      scan_row_q <= scan_row_d;
      div_q      <= div_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      row_sel    <= row_sel_d;
      col_out    <= col_d;
      frame_swap <= do_swap;
    end
  end

  assign frame_out = active_q;

endmodule

// File: tb/tb_matrix_row_scheduler.sv
// Testbench for matrix_row_scheduler (ROWS=4, COLS=12, SCAN_DIV=4).
// A frame-level reference model derives the scan position from the number of
// clocks since reset and tracks shadow/active frames as arrays of row words.
module tb_matrix_row_scheduler;

  localparam int unsigned ROWS     = 4;
  localparam int unsigned COLS     = 12;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned PERIOD   = ROWS * SCAN_DIV;

  logic                 clk;
  logic                 rst;
  logic                 clr;
  logic                 in_valid;
  logic                 in_ready;
  logic [0:COLS-1]      in_data;
  logic [0:ROWS-1]      row_sel;
  logic [0:COLS-1]      col_out;
  logic [0:ROWS*COLS-1] frame_out;
  logic                 frame_swap;

  matrix_row_scheduler #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .row_sel    (row_sel),
    .col_out    (col_out),
    .frame_out  (frame_out),
    .frame_swap (frame_swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [COLS-1:0] m_shadow [ROWS];
  logic [COLS-1:0] m_active [ROWS];
  int              m_cnt;
  int              m_k;        // clocks since reset released
  bit              m_pending;  // full frame waiting for the scan wrap
  bit              m_swap;
  bit              m_known = 1'b0;
  logic            last_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:ROWS-1] onehot(input int r);
    logic [0:ROWS-1] o;
    o    = '0;
    o[r] = 1'b1;
    return o;
  endfunction

  task automatic model_update(input logic r, input logic c, input logic v, input logic [COLS-1:0] d);
    if (r) begin
      for (int i = 0; i < ROWS; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_cnt     = 0;
      m_k       = 0;
      m_pending = 1'b0;
      m_swap    = 1'b0;
      m_known   = 1'b1;
    end else begin
      m_swap = 1'b0;
      if (c) begin
        for (int i = 0; i < ROWS; i++) m_shadow[i] = '0;
        m_cnt     = 0;
        m_pending = 1'b0;
      end else if (m_pending) begin
        if ((m_k % PERIOD) == PERIOD - 1) begin
          for (int i = 0; i < ROWS; i++) m_active[i] = m_shadow[i];
          m_pending = 1'b0;
          m_swap    = 1'b1;
        end
      end else if (v) begin
        m_shadow[m_cnt] = d;
        m_cnt++;
        if (m_cnt == ROWS) begin
          m_cnt     = 0;
          m_pending = 1'b1;
        end
      end
      m_k++;
    end
  endtask

  task automatic check_outputs();
    int                   row;
    logic [0:ROWS*COLS-1] ef;
    row = (m_k / SCAN_DIV) % ROWS;
    for (int i = 0; i < ROWS; i++) ef[i*COLS +: COLS] = m_active[i];
    chk("row_sel", 64'(row_sel), 64'(onehot(row)));
    chk("col_out", 64'(col_out), 64'(m_active[row]));
    chk("frame_out", 64'(frame_out), 64'(ef));
    chk("frame_swap", 64'(frame_swap), 64'(m_swap));
  endtask

  // One clock: drive at negedge, check in_ready before the edge, outputs after it.
  task automatic step(input logic r, input logic c, input logic v, input logic [COLS-1:0] d);
    rst      = r;
    clr      = c;
    in_valid = v;
    in_data  = d;
    #1;
    last_ready = in_ready;
    if (m_known) chk("in_ready", 64'(in_ready), 64'(!m_pending && !c));
    @(posedge clk);
    model_update(r, c, v, d);
    #1;
    if (m_known) check_outputs();
    @(negedge clk);
  endtask

  task automatic wait_swap(input int bound, output int waited);
    bit found;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < bound; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      waited++;
      if (frame_swap === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("swap_seen", 64'(found), 64'(1));
  endtask

  typedef struct {
    logic            vld;
    logic [COLS-1:0] data;
    logic            exp_ready;
    logic [0:ROWS-1] exp_sel;
    logic [COLS-1:0] exp_col;
    logic            exp_swap;
  } vec_t;

  vec_t            vecs [6];
  logic [COLS-1:0] f1 [4];
  int              waited;
  int              swaps;
  bit              hold;
  logic [COLS-1:0] hd;
  logic            rr, rc, rv;
  logic [COLS-1:0] rd;

  initial begin
    vecs[0] = '{1'b1, 12'habc, 1'b1, 4'b1000, 12'h000, 1'b0};
    vecs[1] = '{1'b1, 12'hacf, 1'b1, 4'b1000, 12'h000, 1'b0};
    vecs[2] = '{1'b1, 12'h123, 1'b1, 4'b1000, 12'h000, 1'b0};
    vecs[3] = '{1'b1, 12'h456, 1'b1, 4'b0100, 12'h000, 1'b0};
    vecs[4] = '{1'b0, 12'h000, 1'b0, 4'b0100, 12'h000, 1'b0};
    vecs[5] = '{1'b0, 12'h000, 1'b0, 4'b0100, 12'h000, 1'b0};
    f1[0] = 12'habc; f1[1] = 12'hacf; f1[2] = 12'h123; f1[3] = 12'h456;

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rst_row_sel", 64'(row_sel), 64'(4'b1000));
    chk("rst_col_out", 64'(col_out), 64'(0));
    chk("rst_frame_out", 64'(frame_out), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // First frame loaded back-to-back
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, vecs[i].vld, vecs[i].data);
      chk("tbl_ready", 64'(last_ready), 64'(vecs[i].exp_ready));
      chk("tbl_row_sel", 64'(row_sel), 64'(vecs[i].exp_sel));
      chk("tbl_col_out", 64'(col_out), 64'(vecs[i].exp_col));
      chk("tbl_swap", 64'(frame_swap), 64'(vecs[i].exp_swap));
    end
    wait_swap(20, waited);
    chk("f1_wait", 64'(waited), 64'(10));
    chk("f1_frame", 64'(frame_out), 64'(48'habc_acf_123_456));
    chk("f1_col0", 64'(col_out), 64'(12'habc));
    chk("f1_sel0", 64'(row_sel), 64'(4'b1000));

    // Scan sequence: each row held SCAN_DIV clocks, swap not repeated
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      chk("scan_col", 64'(col_out), 64'(f1[i/4]));
      chk("scan_sel", 64'(row_sel), 64'(onehot(i/4)));
      chk("scan_swap", 64'(frame_swap), 64'(0));
    end

    // Second frame loaded during row 1 must not tear the display
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0);
    chk("tear_sel", 64'(row_sel), 64'(4'b0100));
    step(1'b0, 1'b0, 1'b1, 12'hfff);
    step(1'b0, 1'b0, 1'b1, 12'h000);
    step(1'b0, 1'b0, 1'b1, 12'hfff);
    step(1'b0, 1'b0, 1'b1, 12'h000);
    chk("tear_old", 64'(frame_out), 64'(48'habc_acf_123_456));
    wait_swap(20, waited);
    chk("tear_wait", 64'(waited), 64'(8));
    chk("tear_frame", 64'(frame_out), 64'(48'hfff_000_fff_000));
    chk("tear_col0", 64'(col_out), 64'(12'hfff));

    // clr after two words: nothing commits, then a fresh frame loads normally
    step(1'b0, 1'b0, 1'b1, 12'h111);
    step(1'b0, 1'b0, 1'b1, 12'h222);
    step(1'b0, 1'b1, 1'b1, 12'h333);
    chk("clr_ready", 64'(last_ready), 64'(0));
    swaps = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      if (frame_swap === 1'b1) swaps++;
    end
    chk("clr_no_swap", 64'(swaps), 64'(0));
    chk("clr_active", 64'(frame_out), 64'(48'hfff_000_fff_000));
    step(1'b0, 1'b0, 1'b1, 12'h0a1);
    step(1'b0, 1'b0, 1'b1, 12'h0b2);
    step(1'b0, 1'b0, 1'b1, 12'h0c3);
    step(1'b0, 1'b0, 1'b1, 12'h0d4);
    wait_swap(40, waited);
    chk("clr_reload", 64'(frame_out), 64'(48'h0a1_0b2_0c3_0d4));

    // rst while a frame waits in COMMIT
    step(1'b0, 1'b0, 1'b1, 12'h5a5);
    step(1'b0, 1'b0, 1'b1, 12'ha5a);
    step(1'b0, 1'b0, 1'b1, 12'h5a5);
    step(1'b0, 1'b0, 1'b1, 12'ha5a);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("commit_ready", 64'(last_ready), 64'(0));
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rst6_row_sel", 64'(row_sel), 64'(4'b1000));
    chk("rst6_col_out", 64'(col_out), 64'(0));
    chk("rst6_frame", 64'(frame_out), 64'(0));
    chk("rst6_swap", 64'(frame_swap), 64'(0));
    chk("rst6_ready", 64'(in_ready), 64'(1));
    swaps = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      if (frame_swap === 1'b1) swaps++;
    end
    chk("rst6_no_swap", 64'(swaps), 64'(0));

    // Randomized traffic against the model; stalled words are held stable
    hold = 1'b0;
    hd   = '0;
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 299) == 0);
      rc = ($urandom_range(0, 39) == 0);
      if (hold) begin
        rv = 1'b1;
        rd = hd;
      end else begin
        rv = ($urandom_range(0, 2) != 0);
        rd = 12'($urandom);
      end
      step(rr, rc, rv, rd);
      hold = rv && !last_ready && !rc && !rr;
      hd   = rd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
